// File: rtl/kv_lookup_responder.sv
// Direct-mapped key/value-presence table with LOOKUP/INSERT/DELETE requests.
// One request in flight: accept, synchronous table read, then respond/write.
module kv_lookup_responder #(
    parameter int KEY_SIZE = 96,
    parameter int DEPTH    = 16,
    parameter int IDX_W    = 4
) (
    input  logic                clk156,
    input  logic                eth_rst_n,
    input  logic [KEY_SIZE-1:0] in_key,
    input  logic [3:0]          in_flag,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    output logic [3:0]          out_flag,
    output logic [15:0]         stat_hits,
    output logic [15:0]         stat_reqs
);

    localparam int NSLICE = KEY_SIZE / IDX_W;

    localparam logic [3:0] OP_LOOKUP = 4'b0001;
    localparam logic [3:0] OP_INSERT = 4'b0010;
    localparam logic [3:0] OP_DELETE = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                rdy_q;
    logic [KEY_SIZE-1:0] key_q;
    logic [3:0]          flag_q;
    logic [DEPTH-1:0]    valid_q;
    logic [KEY_SIZE-1:0] key_mem [DEPTH];
    logic [KEY_SIZE-1:0] rd_key_q;
    logic [15:0]         hits_q;
    logic [15:0]         reqs_q;

    logic [IDX_W-1:0]    idx;
    logic                accept;
    logic                entry_valid;
    logic                key_match;
    logic                hit;
    logic                wr_key;
    logic                set_valid;
    logic                clr_valid;
    logic                hit_inc;
    logic [3:0]          resp_flag;

    always_comb begin
        idx = '0;
        for (int i = 0; i < NSLICE; i++) begin
            idx = idx ^ key_q[IDX_W*i +: IDX_W];
        end
    end

    // rdy_q holds in_ready low from reset until the first clock edge after release
    assign in_ready    = rdy_q && (state_q == ST_IDLE);
    assign accept      = in_valid && in_ready;
    assign entry_valid = valid_q[idx];
    assign key_match   = (rd_key_q == key_q);
    assign hit         = entry_valid && key_match;
    assign stat_hits   = hits_q;
    assign stat_reqs   = reqs_q;

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        resp_flag = 4'b0000;
        wr_key    = 1'b0;
        set_valid = 1'b0;
        clr_valid = 1'b0;
        hit_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d   = ST_IDLE;
                out_valid = 1'b1;
                case (flag_q)
                    OP_LOOKUP: begin
                        resp_flag = hit ? 4'b0001 : 4'b0000;
                        hit_inc   = hit;
                    end
                    OP_INSERT: begin
                        wr_key    = 1'b1;
                        set_valid = 1'b1;
                        resp_flag = (entry_valid && !key_match) ? 4'b1010 : 4'b0010;
                    end
                    OP_DELETE: begin
                        clr_valid = hit;
                        resp_flag = hit ? 4'b0100 : 4'b0000;
                    end
                    default: begin
                        resp_flag = 4'b1111;
                    end
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_flag = resp_flag;

    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            key_q   <= '0;
            flag_q  <= '0;
            valid_q <= '0;
            hits_q  <= '0;
            reqs_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            if (accept) begin
                key_q  <= in_key;
                flag_q <= in_flag;
                reqs_q <= reqs_q + 16'd1;
            end
            if (set_valid) begin
                valid_q[idx] <= 1'b1;
            end else if (clr_valid) begin
                valid_q[idx] <= 1'b0;
            end
            if (hit_inc && (hits_q != 16'hFFFF)) begin
                hits_q <= hits_q + 16'd1;
            end
        end
    end

    // Key storage has no reset so it maps onto block RAM; validity lives in valid_q
    always_ff @(posedge clk156) begin
        if (state_q == ST_READ) begin
            rd_key_q <= key_mem[idx];
        end
        if (wr_key) begin
            key_mem[idx] <= key_q;
        end
    end

endmodule

// File: tb/tb_kv_lookup_responder.sv
// Scoreboard bench for kv_lookup_responder: a reference table model predicts
// each response, which is queued at issue time and checked when out_valid fires.
module tb_kv_lookup_responder;

    localparam int KS = 96;
    localparam int D  = 16;
    localparam int IW = 4;

    logic          clk156 = 1'b0;
    logic          eth_rst_n = 1'b0;
    logic [KS-1:0] in_key = '0;
    logic [3:0]    in_flag = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [3:0]    out_flag;
    logic [15:0]   stat_hits;
    logic [15:0]   stat_reqs;

    kv_lookup_responder #(.KEY_SIZE(KS), .DEPTH(D), .IDX_W(IW)) dut (
        .clk156    (clk156),
        .eth_rst_n (eth_rst_n),
        .in_key    (in_key),
        .in_flag   (in_flag),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_flag  (out_flag),
        .stat_hits (stat_hits),
        .stat_reqs (stat_reqs)
    );

    always #5 clk156 = ~clk156;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model
    logic [KS-1:0] m_key [D];
    logic          m_val [D];
    int            m_hits = 0;
    int            m_reqs = 0;

    typedef struct {
        logic [3:0]    flag;
        logic [15:0]   hits;
        logic [15:0]   reqs;
        logic [3:0]    op;
        logic [KS-1:0] key;
    } exp_t;
    exp_t sb[$];

    function automatic logic [IW-1:0] m_idx(input logic [KS-1:0] k);
        logic [IW-1:0] r = '0;
        for (int i = 0; i < KS / IW; i++) begin
            r = r ^ IW'(k >> (IW * i));
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_val[i] = 1'b0;
            m_key[i] = '0;
        end
        m_hits = 0;
        m_reqs = 0;
    endtask

    task automatic model_push(input logic [3:0] op, input logic [KS-1:0] k);
        exp_t          e;
        logic [IW-1:0] ix;
        logic          hm;
        ix = m_idx(k);
        hm = m_val[ix] && (m_key[ix] == k);
        m_reqs = (m_reqs + 1) % 65536;
        e.reqs = 16'(m_reqs);
        e.hits = 16'(m_hits);
        e.op   = op;
        e.key  = k;
        case (op)
            4'b0001: begin
                e.flag = hm ? 4'b0001 : 4'b0000;
                if (hm && m_hits < 65535) m_hits++;
            end
            4'b0010: begin
                e.flag = (m_val[ix] && m_key[ix] != k) ? 4'b1010 : 4'b0010;
                m_val[ix] = 1'b1;
                m_key[ix] = k;
            end
            4'b0100: begin
                e.flag = hm ? 4'b0100 : 4'b0000;
                if (hm) m_val[ix] = 1'b0;
            end
            default: e.flag = 4'b1111;
        endcase
        sb.push_back(e);
    endtask

    // Response monitor
    exp_t mon_e;
    always @(negedge clk156) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 32'(out_valid), 32'(0));
            end else begin
                mon_e = sb.pop_front();
                $display("resp op=%b key=%0h flag=%b (exp %b) hits=%0d reqs=%0d",
                         mon_e.op, mon_e.key, out_flag, mon_e.flag, stat_hits, stat_reqs);
                chk("out_flag", 32'(out_flag), 32'(mon_e.flag));
                chk("stat_hits", 32'(stat_hits), 32'(mon_e.hits));
                chk("stat_reqs", 32'(stat_reqs), 32'(mon_e.reqs));
            end
        end else begin
            chk("idle_out_flag", 32'(out_flag), 32'(0));
        end
    end

    // One request with exact-latency checks; next call lands on T+3
    task automatic issue(input logic [3:0] op, input logic [KS-1:0] k);
        @(negedge clk156);
        chk("in_ready_before_accept", 32'(in_ready), 32'(1));
        in_valid = 1'b1;
        in_flag  = op;
        in_key   = k;
        model_push(op, k);
        @(posedge clk156);
        #1;
        in_valid = 1'b0;
        @(negedge clk156);
        chk("out_valid_t1", 32'(out_valid), 32'(0));
        chk("in_ready_t1", 32'(in_ready), 32'(0));
        @(negedge clk156);
        chk("out_valid_t2", 32'(out_valid), 32'(1));
    endtask

    task automatic reset_release_checks();
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_stat_hits", 32'(stat_hits), 32'(0));
        chk("rst_stat_reqs", 32'(stat_reqs), 32'(0));
        @(negedge clk156);
        eth_rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(in_ready), 32'(0));
        @(negedge clk156);
        chk("ready_after_edge", 32'(in_ready), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [KS-1:0] keys [5];
    int acc;

    initial begin
        model_reset();
        keys[0] = 96'h1;
        keys[1] = 96'h10;
        keys[2] = 96'h01;
        keys[3] = 96'hA5;
        keys[4] = 96'h11;
        repeat (3) @(negedge clk156);
        reset_release_checks();

        // basic miss, insert/lookup back-to-back, eviction
        issue(4'b0001, 96'h1);
        issue(4'b0010, 96'hA5);
        issue(4'b0001, 96'hA5);
        issue(4'b0010, 96'h10);
        issue(4'b0010, 96'h01);
        issue(4'b0001, 96'h10);

        // delete hit, delete miss, lookup after delete
        issue(4'b0100, 96'hA5);
        issue(4'b0100, 96'hA5);
        issue(4'b0001, 96'hA5);

        // illegal opcodes leave the table alone
        issue(4'b0011, 96'h01);
        issue(4'b0000, 96'h01);
        issue(4'b0001, 96'h01);

        // in_valid held high: one accept per three cycles
        in_flag = 4'b0001;
        in_key  = 96'h01;
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk156);
            in_valid = 1'b1;
            if (in_ready) begin
                model_push(4'b0001, 96'h01);
                acc++;
            end
        end
        @(negedge clk156);
        in_valid = 1'b0;
        chk("held_valid_accepts", 32'(acc), 32'(3));
        repeat (3) @(negedge clk156);

        // reset during READ aborts an INSERT
        in_valid = 1'b1;
        in_flag  = 4'b0010;
        in_key   = 96'h777;
        @(posedge clk156);
        #1;
        in_valid = 1'b0;
        #2;
        eth_rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk156);
        reset_release_checks();
        issue(4'b0001, 96'h777);

        // randomised traffic over a few colliding keys
        for (int n = 0; n < 16; n++) begin
            logic [3:0] op;
            case ($urandom_range(0, 3))
                0: op = 4'b0001;
                1: op = 4'b0010;
                2: op = 4'b0100;
                default: op = 4'($urandom_range(0, 15));
            endcase
            issue(op, keys[$urandom_range(0, 4)]);
        end

        repeat (3) @(negedge clk156);
        chk("final_stat_hits", 32'(stat_hits), 32'(m_hits));
        chk("final_stat_reqs", 32'(stat_reqs), 32'(m_reqs));
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kv_lookup_responder.md
KV_LOOKUP_RESPONDER -- requirements
Module: kv_lookup_responder

Interface
REQ-001 SHALL have parameter KEY_SIZE, default 96, request key width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, table entries; power of 2, 2..256.
REQ-003 SHALL have parameter IDX_W, default 4, equal to log2(DEPTH); KEY_SIZE SHALL be a multiple of IDX_W.
REQ-004 SHALL have port clk156  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port eth_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_key  in  KEY_SIZE  request key.
REQ-007 SHALL have port in_flag  in  4  opcode: 4'b0001 LOOKUP, 4'b0010 INSERT, 4'b0100 DELETE.
REQ-008 SHALL have port in_valid  in  1  request valid.
REQ-009 SHALL have port in_ready  out  1  responder can accept a request.
REQ-010 SHALL have port out_valid  out  1  one-cycle response strobe.
REQ-011 SHALL have port out_flag  out  4  response code, valid only while out_valid=1.
REQ-012 SHALL have port stat_hits  out  16  saturating count of LOOKUP hits.
REQ-013 SHALL have port stat_reqs  out  16  wrapping count of accepted requests.

Function
REQ-014 SHALL accept a request in a cycle where in_valid=1 and in_ready=1, registering in_key and in_flag.
REQ-015 SHALL implement FSM IDLE -> READ -> RESP -> IDLE; IDLE->READ on accept; READ->RESP and RESP->IDLE unconditionally.
REQ-016 SHALL drive in_ready=1 only in IDLE; in_valid in READ/RESP is ignored, and no request is dropped or queued.
REQ-017 SHALL assert out_valid for exactly one cycle, two cycles after the accept cycle (accept at T, out_valid at T+2); the next accept is possible at T+3.
REQ-018 SHALL compute index = XOR of all IDX_W-bit slices of the key, slice i = key[IDX_W*i+IDX_W-1 : IDX_W*i].
REQ-019 SHALL store per entry a valid bit and full KEY_SIZE key, in a direct-mapped table; hit = entry valid and stored key == request key.
REQ-020 LOOKUP SHALL respond 4'b0001 on hit and 4'b0000 on miss, with no table change.
REQ-021 INSERT SHALL write key and set valid; response 4'b0010 if the entry was empty or held the same key, 4'b1010 if a different valid key was evicted.
REQ-022 DELETE SHALL clear valid on hit with response 4'b0100, and respond 4'b0000 on miss with no change.
REQ-023 Any other in_flag value, including 0 and multi-bit values, SHALL respond 4'b1111 with no table change.
REQ-024 The table write SHALL occur in the RESP cycle; a request accepted at T+3 SHALL observe it.
REQ-025 stat_reqs SHALL increment on every accept and wrap 16'hFFFF->0; stat_hits SHALL increment on LOOKUP hit in RESP and hold at 16'hFFFF.
REQ-026 out_flag SHALL be 4'b0000 whenever out_valid=0.

Reset
REQ-027 eth_rst_n=0 SHALL immediately force state IDLE, in_ready=0, out_valid=0, out_flag=0, stat_hits=0, stat_reqs=0, and all entry valid bits=0.
REQ-028 in_ready SHALL rise on the first clk156 edge after eth_rst_n deasserts.
REQ-029 Reset asserted in READ or RESP SHALL abort the request with no response and no table write.

Verification
REQ-030 Reset release, then LOOKUP key 96'h1 -> out_valid exactly at T+2, out_flag 4'b0000, stat_reqs=1, stat_hits=0.
REQ-031 INSERT 96'hA5, then LOOKUP 96'hA5 back-to-back (accept at T+3) -> responses 4'b0010 then 4'b0001, stat_hits=1.
REQ-032 INSERT 96'h10, then INSERT 96'h01 (same index 1) -> 4'b0010 then 4'b1010; LOOKUP 96'h10 -> 4'b0000.
REQ-033 DELETE 96'hA5 after insert -> 4'b0100; repeat DELETE -> 4'b0000; LOOKUP -> 4'b0000.
REQ-034 in_flag 4'b0011 and 4'b0000 -> 4'b1111 each, table unchanged; in_valid held high through READ/RESP -> exactly one accept per three cycles.
REQ-035 Assert eth_rst_n=0 in READ after INSERT -> no out_valid; after release, LOOKUP of the same key -> 4'b0000.
